// File: rtl/moving_avg_filter.sv
// moving_avg_filter: streaming moving average over the last 2^LOG2_DEPTH
// accepted samples, with a pushbutton-selected raw pass-through mode.
// The window is a register array with a running sum, so a flush is one cycle.
module moving_avg_filter #(
  parameter int DATA_W     = 8,
  parameter int LOG2_DEPTH = 3
) (
  input  logic              CLOCK_50,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              clear,
  input  logic              toggleBtn,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              primed,
  output logic              LEDG
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int          SUM_W = DATA_W + LOG2_DEPTH;
  localparam int          CNT_W = LOG2_DEPTH + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef enum logic {
    MODE_RAW = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  logic [DATA_W-1:0]     win_q [DEPTH];
  logic [SUM_W-1:0]      sum_q, sum_d, sum_acc;
  logic [LOG2_DEPTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_acc;
  logic                  sync1_q, sync2_q, sync3_q;
  logic                  toggle_edge;
  mode_e                 mode_q, mode_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  primed_q, primed_d;
  logic [DATA_W-1:0]     avg;

  // Next-state for the running sum, pointer, fill count, mode and outputs.
  always_comb begin
    // The intermediate sum_q + in_data may wrap SUM_W, but subtracting the
    // evicted entry brings it back in range, so modular arithmetic is exact.
    sum_acc     = sum_q + SUM_W'(in_data) - SUM_W'(win_q[ptr_q]);
    cnt_acc     = (cnt_q == FULL) ? FULL : cnt_q + CNT_W'(1);
    avg         = DATA_W'(sum_acc >> LOG2_DEPTH);
    toggle_edge = sync2_q & ~sync3_q;

    mode_d      = mode_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    primed_d    = primed_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;

    if (toggle_edge) begin
      mode_d = (mode_q == MODE_AVG) ? MODE_RAW : MODE_AVG;
    end

    if (clear) begin
      sum_d    = '0;
      ptr_d    = '0;
      cnt_d    = '0;
      primed_d = 1'b0;
    end else if (in_valid) begin
      sum_d    = sum_acc;
      ptr_d    = ptr_q + LOG2_DEPTH'(1);
      cnt_d    = cnt_acc;
      primed_d = (cnt_acc == FULL);
      // The output decision uses the mode in force before any same-cycle flip.
      if (mode_q == MODE_RAW) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else if (cnt_acc == FULL) begin
        out_valid_d = 1'b1;
        out_data_d  = avg;
      end
    end
  end

  // Window storage and all registered state; async active-low reset.
  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        win_q[i] <= '0;
      end
      sum_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      sync3_q     <= 1'b0;
      mode_q      <= MODE_AVG;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      primed_q    <= 1'b0;
    end else begin
      if (clear) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          win_q[i] <= '0;
        end
      end else if (in_valid) begin
        win_q[ptr_q] <= in_data;
      end
      sum_q       <= sum_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      sync1_q     <= toggleBtn;
      sync2_q     <= sync1_q;
      sync3_q     <= sync2_q;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      primed_q    <= primed_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign primed    = primed_q;
  assign LEDG      = (mode_q == MODE_AVG);

endmodule

// File: tb/tb_moving_avg_filter.sv
// Testbench for moving_avg_filter: table vectors, hand-written corner
// sequences and randomized traffic against a queue-based window model.
module tb_moving_avg_filter;

  localparam int DATA_W     = 8;
  localparam int LOG2_DEPTH = 3;
  localparam int DEPTH      = 1 << LOG2_DEPTH;

  logic              CLOCK_50 = 1'b0;
  logic              rst_n    = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              clear    = 1'b0;
  logic              toggleBtn = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              primed;
  logic              LEDG;

  moving_avg_filter #(
    .DATA_W    (DATA_W),
    .LOG2_DEPTH(LOG2_DEPTH)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_data  (in_data),
    .clear    (clear),
    .toggleBtn(toggleBtn),
    .out_valid(out_valid),
    .out_data (out_data),
    .primed   (primed),
    .LEDG     (LEDG)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the window is simply the last DEPTH accepted samples
  // since the last flush; the button is judged from its history of samples.
  int unsigned win[$];
  bit          bh[$];
  bit          m_led;
  bit          m_ov;
  int unsigned m_od;
  bit          m_primed;

  task automatic model_reset();
    win.delete();
    bh = '{1'b0, 1'b0, 1'b0};
    m_led    = 1'b1;
    m_ov     = 1'b0;
    m_od     = 0;
    m_primed = 1'b0;
  endtask

  task automatic model_edge(input bit v, input int unsigned d, input bit clr, input bit btn);
    bit          old_mode;
    bit          flip;
    int unsigned s;
    old_mode = m_led;
    // The button flips the mode once it has been seen high two edges back
    // after having been low three edges back.
    flip = bh[1] && !bh[0];
    bh.push_back(btn);
    void'(bh.pop_front());
    if (flip) m_led = !m_led;
    m_ov = 1'b0;
    if (clr) begin
      win.delete();
      m_primed = 1'b0;
    end else if (v) begin
      win.push_back(d);
      if (win.size() > DEPTH) void'(win.pop_front());
      m_primed = (win.size() == DEPTH);
      if (!old_mode) begin
        m_ov = 1'b1;
        m_od = d;
      end else if (win.size() == DEPTH) begin
        s = 0;
        foreach (win[i]) s += win[i];
        m_ov = 1'b1;
        m_od = s / DEPTH;
      end
    end
  endtask

  task automatic step(input bit v, input int unsigned d, input bit clr, input bit btn);
    in_valid  = v;
    in_data   = d[DATA_W-1:0];
    clear     = clr;
    toggleBtn = btn;
    @(posedge CLOCK_50);
    #1;
    if (rst_n) model_edge(v, d, clr, btn);
    else       model_reset();
    check("model_out_valid", {31'b0, out_valid}, {31'b0, m_ov});
    check("model_out_data",  {24'b0, out_data},  m_od);
    check("model_primed",    {31'b0, primed},    {31'b0, m_primed});
    check("model_LEDG",      {31'b0, LEDG},      {31'b0, m_led});
  endtask

  typedef struct {
    bit          v;
    int unsigned d;
    bit          clr;
    bit          ov;
    int unsigned od;
    bit          pr;
  } vec_t;

  function automatic vec_t mk(bit v, int unsigned d, bit clr, bit ov, int unsigned od, bit pr);
    vec_t r;
    r.v = v; r.d = d; r.clr = clr; r.ov = ov; r.od = od; r.pr = pr;
    return r;
  endfunction

  vec_t        tbl[$];
  int unsigned sat_exp[8] = '{43, 73, 104, 134, 165, 195, 225, 255};
  bit          btn_r;
  bit          prev_led;
  int          flips;

  initial begin
    // Priming 1..8, wrap with 9..16 (avg = n-4), then saturation with 255s.
    for (int i = 1; i <= 8; i++)
      tbl.push_back(mk(1'b1, i, 1'b0, i == 8, (i == 8) ? 4 : 0, i == 8));
    for (int n = 9; n <= 16; n++)
      tbl.push_back(mk(1'b1, n, 1'b0, 1'b1, n - 4, 1'b1));
    for (int j = 0; j < 8; j++)
      tbl.push_back(mk(1'b1, 255, 1'b0, 1'b1, sat_exp[j], 1'b1));

    model_reset();

    // Reset with stimulus active.
    in_valid = 1'b1;
    in_data  = 8'hAB;
    repeat (3) @(posedge CLOCK_50);
    #1;
    check("rst_out_valid", {31'b0, out_valid}, 0);
    check("rst_out_data",  {24'b0, out_data},  0);
    check("rst_primed",    {31'b0, primed},    0);
    check("rst_LEDG",      {31'b0, LEDG},      1);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 0, 1'b0, 1'b0);
      check("idle_out_valid", {31'b0, out_valid}, 0);
      check("idle_out_data",  {24'b0, out_data},  0);
      check("idle_LEDG",      {31'b0, LEDG},      1);
    end

    // Table vectors.
    foreach (tbl[k]) begin
      step(tbl[k].v, tbl[k].d, tbl[k].clr, 1'b0);
      check("tbl_out_valid", {31'b0, out_valid}, {31'b0, tbl[k].ov});
      check("tbl_out_data",  {24'b0, out_data},  tbl[k].od);
      check("tbl_primed",    {31'b0, primed},    {31'b0, tbl[k].pr});
    end

    // Clear together with a sample: sample dropped, out_data held.
    step(1'b1, 50, 1'b1, 1'b0);
    check("clr_out_valid", {31'b0, out_valid}, 0);
    check("clr_primed",    {31'b0, primed},    0);
    check("clr_out_data",  {24'b0, out_data},  255);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 80, 1'b0, 1'b0);
      check("reprime_out_valid", {31'b0, out_valid}, (i == 8) ? 1 : 0);
      check("reprime_out_data",  {24'b0, out_data},  (i == 8) ? 80 : 255);
    end

    // Mode toggle: LEDG changes on the third edge after the press.
    step(1'b0, 0, 1'b0, 1'b1);
    check("tog_LEDG_e1", {31'b0, LEDG}, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check("tog_LEDG_e2", {31'b0, LEDG}, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    check("tog_LEDG_e3", {31'b0, LEDG}, 0);
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b1, 7, 1'b0, 1'b0);
    check("raw_out_valid_7", {31'b0, out_valid}, 1);
    check("raw_out_data_7",  {24'b0, out_data},  7);
    step(1'b1, 200, 1'b0, 1'b0);
    check("raw_out_valid_200", {31'b0, out_valid}, 1);
    check("raw_out_data_200",  {24'b0, out_data},  200);
    repeat (3) step(1'b0, 0, 1'b0, 1'b1);
    check("tog_back_LEDG", {31'b0, LEDG}, 1);
    repeat (2) step(1'b0, 0, 1'b0, 1'b0);
    // Window: six 80s, 7, 200 then an 80 replaces an 80 -> 687/8 = 85.
    step(1'b1, 80, 1'b0, 1'b0);
    check("avg_after_raw_valid", {31'b0, out_valid}, 1);
    check("avg_after_raw_data",  {24'b0, out_data},  85);

    // Button held high: exactly one flip.
    flips = 0;
    for (int i = 0; i < 20; i++) begin
      prev_led = LEDG;
      step(1'b0, 0, 1'b0, 1'b1);
      if (LEDG != prev_led) flips++;
    end
    for (int i = 0; i < 4; i++) begin
      prev_led = LEDG;
      step(1'b0, 0, 1'b0, 1'b0);
      if (LEDG != prev_led) flips++;
    end
    check("held_flip_count", flips, 1);
    check("held_LEDG", {31'b0, LEDG}, 0);

    // Randomized traffic.
    btn_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 15) == 0) btn_r = !btn_r;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 255),
           $urandom_range(0, 39) == 0, btn_r);
    end
    repeat (4) step(1'b0, 0, 1'b0, 1'b0);

    // Reset in the middle of a burst.
    for (int i = 0; i < 5; i++) step(1'b1, $urandom_range(0, 255), 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'b0, out_valid}, 0);
    check("midrst_out_data",  {24'b0, out_data},  0);
    check("midrst_primed",    {31'b0, primed},    0);
    check("midrst_LEDG",      {31'b0, LEDG},      1);
    model_reset();
    step(1'b1, 99, 1'b0, 1'b0);
    step(1'b1, 99, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 10, 1'b0, 1'b0);
      check("postrst_out_valid", {31'b0, out_valid}, (i == 8) ? 1 : 0);
    end
    check("postrst_out_data", {24'b0, out_data}, 10);
    check("postrst_primed",   {31'b0, primed},   1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
